// File: rtl/write_back_stage.sv
// MEM/WB stage: retires ALU results immediately, waits (bounded) for load data,
// and drives one-cycle registered write pulses into the register file.
module write_back_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT    = 15,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      inValid,
   output logic                      inReady,
   input  logic [1:0]                writeBackControlIn,
   input  logic [REG_ADDR_WIDTH-1:0] destRegister,
   input  logic [DATA_WIDTH-1:0]     aluResult,
   input  logic [DATA_WIDTH-1:0]     memReadData,
   input  logic                      memDataValid,
   input  logic                      flush,
   output logic                      regWrite,
   output logic [REG_ADDR_WIDTH-1:0] writeRegister,
   output logic [DATA_WIDTH-1:0]     writeData,
   output logic                      memTimeout,
   output logic [COUNT_WIDTH-1:0]    retiredCount
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   state_t                    state_r, state_nxt_s;
   logic [WAIT_W-1:0]         wait_cnt_r, wait_cnt_nxt_s;
   logic [REG_ADDR_WIDTH-1:0] load_dest_r, load_dest_nxt_s;
   logic                      reg_write_nxt_s;
   logic [REG_ADDR_WIDTH-1:0] write_reg_nxt_s;
   logic [DATA_WIDTH-1:0]     write_data_nxt_s;
   logic                      timeout_nxt_s;
   logic [COUNT_WIDTH-1:0]    count_nxt_s;

   assign inReady = (state_r == IDLE);

   // Next-state and next-output logic; flush overrides both acceptance and load completion.
   always_comb begin
      state_nxt_s      = state_r;
      wait_cnt_nxt_s   = wait_cnt_r;
      load_dest_nxt_s  = load_dest_r;
      reg_write_nxt_s  = 1'b0;
      write_reg_nxt_s  = writeRegister;
      write_data_nxt_s = writeData;
      timeout_nxt_s    = memTimeout;
      count_nxt_s      = retiredCount;
      if (flush) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (inValid) begin
                  if (writeBackControlIn == 2'b11) begin
                     load_dest_nxt_s = destRegister;
                     wait_cnt_nxt_s  = {WAIT_W{1'b0}};
                     state_nxt_s     = WAIT_MEM;
                  end else begin
                     // Loads without a write request retire like ALU ops with no write.
                     write_reg_nxt_s  = destRegister;
                     write_data_nxt_s = aluResult;
                     reg_write_nxt_s  = writeBackControlIn[1] & (destRegister != REG_ZERO);
                     count_nxt_s      = retiredCount + COUNT_WIDTH'(1);
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            WAIT_MEM: begin
               if (memDataValid) begin
                  write_reg_nxt_s  = load_dest_r;
                  write_data_nxt_s = memReadData;
                  reg_write_nxt_s  = (load_dest_r != REG_ZERO);
                  count_nxt_s      = retiredCount + COUNT_WIDTH'(1);
                  state_nxt_s      = IDLE;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  timeout_nxt_s = 1'b1;
                  state_nxt_s   = IDLE;
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // State and registered outputs; synchronous reset takes priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         wait_cnt_r    <= {WAIT_W{1'b0}};
         load_dest_r   <= REG_ZERO;
         regWrite      <= 1'b0;
         writeRegister <= REG_ZERO;
         writeData     <= {DATA_WIDTH{1'b0}};
         memTimeout    <= 1'b0;
         retiredCount  <= {COUNT_WIDTH{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         load_dest_r   <= load_dest_nxt_s;
         regWrite      <= reg_write_nxt_s;
         writeRegister <= write_reg_nxt_s;
         writeData     <= write_data_nxt_s;
         memTimeout    <= timeout_nxt_s;
         retiredCount  <= count_nxt_s;
      end
   end

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model.
module tb_write_back_stage;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int TMO = 15;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          inValid = 1'b0;
   logic          inReady;
   logic [1:0]    ctrl = 2'b00;
   logic [AW-1:0] dest = '0;
   logic [DW-1:0] alu = '0;
   logic [DW-1:0] mdata = '0;
   logic          mvalid = 1'b0;
   logic          flush = 1'b0;
   logic          regWrite;
   logic [AW-1:0] writeRegister;
   logic [DW-1:0] writeData;
   logic          memTimeout;
   logic [CW-1:0] retiredCount;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   // model: a load is "outstanding" with a known destination and a count of empty cycles
   bit            m_outstanding = 1'b0;
   int            m_empty_cycles = 0;
   logic [AW-1:0] m_load_dest = '0;
   bit            m_rw = 1'b0;
   logic [AW-1:0] m_wreg = '0;
   logic [DW-1:0] m_wdata = '0;
   bit            m_tmo = 1'b0;
   int            m_count = 0;

   write_back_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(TMO), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
      .writeBackControlIn(ctrl), .destRegister(dest), .aluResult(alu),
      .memReadData(mdata), .memDataValid(mvalid), .flush(flush),
      .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
      .memTimeout(memTimeout), .retiredCount(retiredCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: what each retiring transaction must produce
   always @(posedge clk) begin
      if (reset) begin
         m_outstanding = 1'b0; m_empty_cycles = 0; m_load_dest = '0;
         m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_tmo = 1'b0; m_count = 0;
      end else begin
         m_rw = 1'b0;
         if (flush) begin
            m_outstanding = 1'b0;
         end else if (!m_outstanding) begin
            if (inValid && ctrl == 2'b11) begin
               m_outstanding = 1'b1; m_load_dest = dest; m_empty_cycles = 0;
            end else if (inValid) begin
               m_wreg = dest; m_wdata = alu; m_rw = ctrl[1] && (dest != 0);
               m_count = (m_count + 1) % (1 << CW);
            end
         end else if (mvalid) begin
            m_wreg = m_load_dest; m_wdata = mdata; m_rw = (m_load_dest != 0);
            m_count = (m_count + 1) % (1 << CW);
            m_outstanding = 1'b0;
         end else begin
            m_empty_cycles++;
            if (m_empty_cycles >= TMO) begin
               m_tmo = 1'b1; m_outstanding = 1'b0;
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("inReady", DW'(inReady), DW'(!m_outstanding));
         chk("regWrite", DW'(regWrite), DW'(m_rw));
         chk("writeRegister", DW'(writeRegister), DW'(m_wreg));
         chk("writeData", writeData, m_wdata);
         chk("memTimeout", DW'(memTimeout), DW'(m_tmo));
         chk("retiredCount", DW'(retiredCount), DW'(m_count));
      end
   end

   task automatic step(input bit v, input logic [1:0] c, input logic [AW-1:0] d,
                       input logic [DW-1:0] a, input bit mv, input logic [DW-1:0] md,
                       input bit fl, input bit rs);
      inValid = v; ctrl = c; dest = d; alu = a; mvalid = mv; mdata = md; flush = fl; reset = rs;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      step(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      check_en = 1'b1;
      chk("rst_regWrite", DW'(regWrite), 32'd0);
      chk("rst_inReady", DW'(inReady), 32'd1);
      chk("rst_count", DW'(retiredCount), 32'd0);
      chk("rst_wdata", writeData, 32'd0);

      step(1'b1, 2'b10, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("alu1_rw", DW'(regWrite), 32'd1);
      chk("alu1_reg", DW'(writeRegister), 32'd1);
      chk("alu1_data", writeData, 32'hFFFF_FFFF);
      idle();
      chk("alu1_pulse_end", DW'(regWrite), 32'd0);
      chk("alu1_count", DW'(retiredCount), 32'd1);

      for (int i = 2; i <= 4; i++) begin
         step(1'b1, 2'b10, AW'(i), DW'(32'hA000 + i), 1'b0, 32'h0, 1'b0, 1'b0);
         chk("b2b_rw", DW'(regWrite), 32'd1);
         chk("b2b_reg", DW'(writeRegister), DW'(i));
         chk("b2b_ready", DW'(inReady), 32'd1);
      end
      chk("b2b_count", DW'(retiredCount), 32'd4);

      step(1'b1, 2'b11, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("load_wait_ready", DW'(inReady), 32'd0);
         step(1'b1, 2'b10, 5'd6, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      step(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      chk("load_rw", DW'(regWrite), 32'd1);
      chk("load_reg", DW'(writeRegister), 32'd5);
      chk("load_data", writeData, 32'h1234_5678);
      chk("load_count", DW'(retiredCount), 32'd5);

      step(1'b1, 2'b10, 5'd0, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("r0_rw", DW'(regWrite), 32'd0);
      chk("r0_count", DW'(retiredCount), 32'd6);

      step(1'b1, 2'b11, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 1; i <= TMO; i++) begin
         idle();
         if (i == TMO - 1) begin
            chk("tmo_early_ready", DW'(inReady), 32'd0);
            chk("tmo_early_flag", DW'(memTimeout), 32'd0);
         end
      end
      chk("tmo_flag", DW'(memTimeout), 32'd1);
      chk("tmo_ready", DW'(inReady), 32'd1);
      chk("tmo_count", DW'(retiredCount), 32'd6);

      step(1'b1, 2'b11, 5'd8, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'hCAFE, 1'b1, 1'b0);
      chk("flush_rw", DW'(regWrite), 32'd0);
      chk("flush_ready", DW'(inReady), 32'd1);
      chk("flush_count", DW'(retiredCount), 32'd6);

      step(1'b1, 2'b11, 5'd9, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'hBEEF, 1'b0, 1'b1);
      chk("midrst_rw", DW'(regWrite), 32'd0);
      chk("midrst_tmo", DW'(memTimeout), 32'd0);
      chk("midrst_count", DW'(retiredCount), 32'd0);
      chk("midrst_data", writeData, 32'd0);
      chk("midrst_ready", DW'(inReady), 32'd1);

      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
              DW'($urandom), ($urandom_range(0, 7) == 0), DW'($urandom),
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
